output_port_scheduler: RTL and testbench
========================================

OUTPUT_PORT_SCHEDULER -- requirements
Module: output_port_scheduler

Interface
REQ-001 Parameter CRED_DEPTH, default 4, SHALL set the per-output downstream buffer depth in flits, legal range 1..7.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  reset, synchronous and active-low; SHALL be sampled only on the rising edge of clk.
REQ-004 req_targ  input  15  five 3-bit target fields; input k uses bits [3k+2:3k]; 0 = no request, 1..5 = output port, 6..7 = illegal.
REQ-005 cred_ret  input  4  one-cycle credit-return pulse per output port 1..4.
REQ-006 gnt  output  5  registered per-input grant and pop pulse; one cycle per granted flit.
REQ-007 out_sel  output  15  per-output 3-bit crossbar select; 0 = idle, k = input k.
REQ-008 out_vld  output  5  per-output valid, high when out_sel is nonzero.
REQ-009 credits  output  12  per-output credit count for outputs 1..4, 3 bits each.
REQ-010 err  output  2  sticky error flags; bit0 = credit overflow, bit1 = illegal target.

Function
REQ-011 The block SHALL arbitrate independently for each output o in 1..5, using one round-robin pointer per output with values 0..4.
REQ-012 An input SHALL be eligible for output o when its target equals o and its gnt bit is currently 0.
- This mask prevents a double grant of the same flit.
REQ-013 Outputs 1..4 SHALL grant only when their credit count is greater than 0.
REQ-014 Output 5 (local ejection) SHALL have no credit check.
REQ-015 Among eligible inputs, the winner SHALL be the first one found scanning from the pointer index upward, modulo 5.
REQ-016 After a grant, the pointer SHALL be set to (winner+1) mod 5; when no grant is made, the pointer SHALL be unchanged.
REQ-017 Latency SHALL be one cycle: a request sampled at edge N produces gnt, out_sel and out_vld valid for the cycle after edge N.
- gnt, out_sel and out_vld SHALL all be registered and mutually consistent.
REQ-018 Each input SHALL receive at most one grant per cycle.
- Each output SHALL give at most one grant per cycle.
- All five outputs MAY grant in the same cycle.
REQ-019 Credit counters for outputs 1..4 SHALL update as follows:
- decrement by 1 on a grant;
- increment by 1 on cred_ret;
- stay unchanged when both occur at the same edge.
REQ-020 cred_ret arriving at a counter already equal to CRED_DEPTH, with no grant at the same edge, SHALL be ignored.
- In that case err[0] SHALL be set.
REQ-021 An illegal target (6 or 7) SHALL never be granted.
- In that case err[1] SHALL be set.
REQ-022 err bits SHALL be cleared only by reset.
REQ-023 The credit count SHALL never go below 0 or above CRED_DEPTH.
REQ-024 A request may be withdrawn or changed at any cycle without a grant; the block SHALL keep no per-request state beyond the gnt mask.

Reset
REQ-025 While rst=0 at a rising edge, the block SHALL set:
- gnt=0, out_sel=0, out_vld=0, err=0;
- all pointers to 0;
- all credit counters to CRED_DEPTH.
REQ-026 Reset asserted mid-operation SHALL discard pending grants in that same edge.
- Arbitration SHALL resume on the first edge with rst=1.

Verification
REQ-027 The bench SHALL cover these directed scenarios with CRED_DEPTH=4:
- Reset: hold rst=0 for 2 cycles -> gnt=0, out_sel=0, out_vld=0, err=0, credits=12'o4444.
- Single request: input1 req_targ=3 for one cycle -> next cycle gnt=5'b00001, out_sel[8:6]=1, out_vld=5'b00100, then credits field 3 = 3.
- Round-robin: inputs 1, 2, 4 hold target 2 with credits available -> grants to output 2 on consecutive cycles in order 1, 2, 4, 1; no input granted in two consecutive cycles.
- Credit exhaustion: input3 holds target 1 with no cred_ret -> exactly 4 grants, then stall with credits field 1 = 0; one cred_ret[0] pulse -> exactly one further grant on the next cycle.
- Simultaneous and overflow: grant and cred_ret on output 4 at the same edge -> count unchanged; cred_ret[1] while output 2 count=4 -> count stays 4 and err=2'b01.
- Illegal target and mid-run reset: input5 req_targ=6 -> no grant and err[1]=1; rst=0 asserted during contention -> all outputs 0 and credits restored to 4 at that edge.

Source files
------------

// File: rtl/output_port_scheduler.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// output_port_scheduler
//
// Five-input, five-output crossbar scheduler. Each output runs its own
// round-robin arbiter over the five inputs. Outputs 1..4 are credit-limited
// against a downstream buffer of CRED_DEPTH flits; output 5 is local ejection
// and always accepts.
//
// Handshake: an input presents a target in req_targ. A one-cycle pulse on its
// gnt bit is both the grant and the pop of that flit. The requester must treat
// the flit as consumed on that cycle and present the next target (or 0) from
// then on. While its gnt bit is high, the input is masked from arbitration so
// the same flit is never granted twice.
//
// Ports
//   clk       in   1   clock, rising edge
//   rst       in   1   synchronous active-low reset
//   req_targ  in  15   input k (0..4) target in [3k+2:3k]; 0 idle, 1..5 port, 6..7 illegal
//   cred_ret  in   4   credit-return pulse, bit o-1 for output o (1..4)
//   gnt       out  5   registered grant/pop pulse per input
//   out_sel   out 15   output o select in [3(o-1)+2:3(o-1)]; 0 idle, k = input k
//   out_vld   out  5   output o valid (out_sel field nonzero)
//   credits   out 12   credit count of outputs 1..4, 3 bits each
//   err       out  2   sticky: bit0 credit overflow, bit1 illegal target
// ---------------------------------------------------------------------------
module output_port_scheduler #(
    parameter int CRED_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [14:0] req_targ,
    input  logic [3:0]  cred_ret,
    output logic [4:0]  gnt,
    output logic [14:0] out_sel,
    output logic [4:0]  out_vld,
    output logic [11:0] credits,
    output logic [1:0]  err
);

    localparam logic [2:0] FULL = 3'(CRED_DEPTH);

    logic [4:0]  r_gnt;
    logic [14:0] r_sel;
    logic [4:0]  r_vld;
    logic [1:0]  r_err;
    logic [2:0]  r_ptr  [5];
    logic [2:0]  r_cred [4];

    logic [4:0]  w_cred_ok;
    logic [14:0] w_sel;
    logic [4:0]  w_gnt;
    logic [4:0]  w_vld;
    logic        w_illegal;

    // Returns winner+1 (1..5) for one output, or 0 when nobody is eligible.
    // Scanning offsets from high to low lets the lowest offset from the
    // pointer overwrite the others, i.e. the first match wins.
    function automatic logic [2:0] f_pick(
        input logic [14:0] req,
        input logic [4:0]  mask,
        input logic [2:0]  ptr,
        input logic [2:0]  targ,
        input logic        ok
    );
        logic [2:0] win;
        int         t;
        win = 3'd0;
        for (int j = 4; j >= 0; j--) begin
            t = int'(ptr) + j;
            if (t >= 5) t = t - 5;
            if (ok && (req[3*t +: 3] == targ) && !mask[t])
                win = 3'(t + 1);
        end
        return win;
    endfunction

    always_comb begin
        w_cred_ok = 5'b10000;
        w_sel     = '0;
        w_gnt     = '0;
        w_vld     = '0;
        w_illegal = 1'b0;
        for (int o = 0; o < 4; o++)
            w_cred_ok[o] = (r_cred[o] != 3'd0);
        for (int o = 0; o < 5; o++) begin
            w_sel[3*o +: 3] = f_pick(req_targ, r_gnt, r_ptr[o], 3'(o + 1), w_cred_ok[o]);
            if (w_sel[3*o +: 3] != 3'd0) begin
                w_vld[o] = 1'b1;
                // Each input carries one target, so at most one output can pick it.
                w_gnt[int'(w_sel[3*o +: 3]) - 1] = 1'b1;
            end
        end
        for (int k = 0; k < 5; k++)
            if (req_targ[3*k +: 3] >= 3'd6) w_illegal = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_gnt <= '0;
            r_sel <= '0;
            r_vld <= '0;
            r_err <= '0;
            for (int o = 0; o < 5; o++) r_ptr[o] <= 3'd0;
            for (int o = 0; o < 4; o++) r_cred[o] <= FULL;
        end else begin
            r_gnt <= w_gnt;
            r_sel <= w_sel;
            r_vld <= w_vld;
            if (w_illegal) r_err[1] <= 1'b1;
            for (int o = 0; o < 5; o++) begin
                // Winner index is sel-1, so winner+1 mod 5 is sel with 5 wrapping to 0.
                if (w_vld[o])
                    r_ptr[o] <= (w_sel[3*o +: 3] == 3'd5) ? 3'd0 : w_sel[3*o +: 3];
            end
            for (int o = 0; o < 4; o++) begin
                case ({w_vld[o], cred_ret[o]})
                    2'b10: r_cred[o] <= r_cred[o] - 3'd1;  // grant implies count > 0
                    2'b01: begin
                        if (r_cred[o] == FULL) r_err[0] <= 1'b1;
                        else                   r_cred[o] <= r_cred[o] + 3'd1;
                    end
                    default: ;  // idle, or grant and return cancel out
                endcase
            end
        end
    end

    always_comb begin
        credits = '0;
        for (int o = 0; o < 4; o++) credits[3*o +: 3] = r_cred[o];
    end

    assign gnt     = r_gnt;
    assign out_sel = r_sel;
    assign out_vld = r_vld;
    assign err     = r_err;

endmodule

// File: tb/tb_output_port_scheduler.sv
`timescale 1ns/1ps
module tb_output_port_scheduler;

  logic        clk;
  logic        rst;
  logic [14:0] req_targ;
  logic [3:0]  cred_ret;
  logic [4:0]  gnt;
  logic [14:0] out_sel;
  logic [4:0]  out_vld;
  logic [11:0] credits;
  logic [1:0]  err;

  int checks = 0;
  int errors = 0;

  output_port_scheduler #(.CRED_DEPTH(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .req_targ (req_targ),
    .cred_ret (cred_ret),
    .gnt      (gnt),
    .out_sel  (out_sel),
    .out_vld  (out_vld),
    .credits  (credits),
    .err      (err)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver tasks: inputs change and outputs are sampled 1ns after the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst      = 1'b0;
    req_targ = '0;
    cred_ret = '0;
    step();
    rst = 1'b1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  int          n_gnt;
  logic [4:0]  prev_gnt;

  initial begin
    rst      = 1'b0;
    req_targ = '0;
    cred_ret = '0;

    // reset held for two cycles
    step();
    step();
    chk("rst_gnt", 32'(gnt), 32'h0);
    chk("rst_sel", 32'(out_sel), 32'h0);
    chk("rst_vld", 32'(out_vld), 32'h0);
    chk("rst_err", 32'(err), 32'h0);
    chk("rst_cred", 32'(credits), 32'(12'o4444));

    // single request: input1 -> output3
    rst      = 1'b1;
    req_targ = 15'o00003;
    step();
    chk("single_gnt", 32'(gnt), 32'(5'b00001));
    chk("single_sel", 32'(out_sel), 32'(15'o00100));
    chk("single_vld", 32'(out_vld), 32'(5'b00100));
    chk("single_cred", 32'(credits), 32'(12'o4344));
    req_targ = '0;
    step();
    chk("single_idle_gnt", 32'(gnt), 32'h0);
    chk("single_idle_vld", 32'(out_vld), 32'h0);

    // round robin: inputs 1,2,4 -> output2, expected winners 1,2,4,1
    do_reset();
    req_targ = 15'o02022;
    prev_gnt = '0;
    step();
    chk("rr0_gnt", 32'(gnt), 32'(5'b00001));
    chk("rr0_sel", 32'(out_sel), 32'(15'o00010));
    chk("rr0_vld", 32'(out_vld), 32'(5'b00010));
    prev_gnt = gnt;
    step();
    chk("rr1_gnt", 32'(gnt), 32'(5'b00010));
    chk("rr1_sel", 32'(out_sel), 32'(15'o00020));
    chk("rr1_nobk", 32'(gnt & prev_gnt), 32'h0);
    prev_gnt = gnt;
    step();
    chk("rr2_gnt", 32'(gnt), 32'(5'b01000));
    chk("rr2_sel", 32'(out_sel), 32'(15'o00040));
    chk("rr2_nobk", 32'(gnt & prev_gnt), 32'h0);
    prev_gnt = gnt;
    step();
    chk("rr3_gnt", 32'(gnt), 32'(5'b00001));
    chk("rr3_sel", 32'(out_sel), 32'(15'o00010));
    chk("rr3_nobk", 32'(gnt & prev_gnt), 32'h0);
    chk("rr3_cred", 32'(credits), 32'(12'o4404));

    // credit exhaustion: input3 -> output1, no returns
    do_reset();
    req_targ = 15'o00100;
    n_gnt    = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (gnt[2]) n_gnt++;
    end
    chk("exh_count", 32'(n_gnt), 32'd4);
    chk("exh_cred", 32'(credits), 32'(12'o4440));
    chk("exh_stall", 32'(gnt), 32'h0);
    cred_ret = 4'b0001;
    step();
    cred_ret = '0;
    chk("exh_ret_cred", 32'(credits), 32'(12'o4441));
    chk("exh_ret_gnt", 32'(gnt), 32'h0);
    step();
    chk("exh_regrant", 32'(gnt), 32'(5'b00100));
    chk("exh_regrant_sel", 32'(out_sel), 32'(15'o00003));
    chk("exh_cred0", 32'(credits), 32'(12'o4440));
    n_gnt = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (gnt != 5'b0) n_gnt++;
    end
    chk("exh_no_more", 32'(n_gnt), 32'd0);

    // simultaneous grant and return on output4, then overflow on output2
    do_reset();
    req_targ = 15'o00004;
    step();
    chk("sim_first_gnt", 32'(gnt), 32'(5'b00001));
    chk("sim_first_cred", 32'(credits), 32'(12'o3444));
    step();
    chk("sim_masked", 32'(gnt), 32'h0);
    cred_ret = 4'b1000;
    step();
    chk("sim_gnt", 32'(gnt), 32'(5'b00001));
    chk("sim_cred", 32'(credits), 32'(12'o3444));
    chk("sim_err", 32'(err), 32'h0);
    req_targ = '0;
    cred_ret = 4'b0010;
    step();
    cred_ret = '0;
    chk("ovf_cred", 32'(credits), 32'(12'o3444));
    chk("ovf_err", 32'(err), 32'(2'b01));
    step();
    chk("ovf_sticky", 32'(err), 32'(2'b01));

    // illegal target on input5
    req_targ = 15'o60000;
    step();
    chk("ill_gnt", 32'(gnt), 32'h0);
    chk("ill_vld", 32'(out_vld), 32'h0);
    chk("ill_err", 32'(err), 32'(2'b11));
    req_targ = '0;
    step();
    chk("ill_sticky", 32'(err), 32'(2'b11));

    // contention then reset mid-run: inputs1,2 -> out1, inputs3,4,5 -> out5
    req_targ = 15'o55511;
    step();
    chk("cont_gnt", 32'(gnt), 32'(5'b00101));
    chk("cont_sel", 32'(out_sel), 32'(15'o30001));
    chk("cont_vld", 32'(out_vld), 32'(5'b10001));
    chk("cont_cred", 32'(credits), 32'(12'o3443));
    rst = 1'b0;
    step();
    chk("mrst_gnt", 32'(gnt), 32'h0);
    chk("mrst_sel", 32'(out_sel), 32'h0);
    chk("mrst_vld", 32'(out_vld), 32'h0);
    chk("mrst_err", 32'(err), 32'h0);
    chk("mrst_cred", 32'(credits), 32'(12'o4444));
    rst = 1'b1;
    step();
    chk("resume_gnt", 32'(gnt), 32'(5'b00101));
    chk("resume_sel", 32'(out_sel), 32'(15'o30001));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
